// File: rtl/riscv_pkg.sv
// Shared RISC-V constants, return-address-stack op classes and the pre-decode entry
// format used by the fetch pre-decode stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        RAS_NONE     = 2'd0,
        RAS_CALL     = 2'd1,
        RAS_RET      = 2'd2,
        RAS_CALL_RET = 2'd3
    } ras_op_cls_t;

    // One buffered instruction with its classification captured at entry
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        ras_op_cls_t     cls;
        logic            is_jal;
        logic [XLEN-1:0] jal_target;
    } pd_entry_t;

    function automatic logic is_link_reg(input logic [4:0] r, input logic x5_en);
        return (r == 5'd1) || (x5_en && (r == 5'd5));
    endfunction

endpackage

// File: rtl/predecode_classify.sv
// Combinational classifier: sorts an instruction into a RAS op class and
// computes the JAL target.
module predecode_classify
    import riscv_pkg::*;
#(
    parameter bit LINK_X5_EN = 1'b1
) (
    input  logic [ILEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    output ras_op_cls_t     cls,
    output logic            is_jal,
    output logic [XLEN-1:0] jal_target
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            rd_link;
    logic            rs1_link;
    logic [XLEN-1:0] j_imm;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign rs1      = instr[19:15];
    assign rd_link  = is_link_reg(rd, LINK_X5_EN);
    assign rs1_link = is_link_reg(rs1, LINK_X5_EN);

    assign j_imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign jal_target = pc + j_imm;

    // JALR with both link registers: a differing pair is a coroutine swap (pop then push)
    always_comb begin
        cls    = RAS_NONE;
        is_jal = 1'b0;
        case (opcode)
            OPC_JAL: begin
                is_jal = 1'b1;
                cls    = rd_link ? RAS_CALL : RAS_NONE;
            end
            OPC_JALR: begin
                if (!rd_link && rs1_link) begin
                    cls = RAS_RET;
                end else if (rd_link && !rs1_link) begin
                    cls = RAS_CALL;
                end else if (rd_link && rs1_link) begin
                    cls = (rd != rs1) ? RAS_CALL_RET : RAS_CALL;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_predecode.sv
// Registered pre-decode stage with a main + skid buffer; drives RAS push/pop and
// early redirects for JAL targets and RAS-predicted returns.
module fetch_predecode
    import riscv_pkg::*;
#(
    parameter bit LINK_X5_EN = 1'b1,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target,
    output logic            ras_push,
    output logic            ras_pop,
    output logic [XLEN-1:0] ras_return_addr,
    input  logic [XLEN-1:0] ras_predicted_return,
    input  logic            ras_valid
);

    pd_entry_t   main_q, main_d;
    pd_entry_t   skid_q, skid_d;
    logic        main_valid, main_valid_d;
    logic        skid_valid, skid_valid_d;
    pd_entry_t   in_entry;
    ras_op_cls_t in_cls;
    logic        in_is_jal;
    logic [XLEN-1:0] in_jal_target;
    logic        in_fire;
    logic        out_fire;

    predecode_classify #(
        .LINK_X5_EN (LINK_X5_EN)
    ) u_classify (
        .instr      (in_instr),
        .pc         (in_pc),
        .cls        (in_cls),
        .is_jal     (in_is_jal),
        .jal_target (in_jal_target)
    );

    assign in_entry = '{pc: in_pc, instr: in_instr, cls: in_cls,
                        is_jal: in_is_jal, jal_target: in_jal_target};

    assign in_ready  = SKID_EN ? !skid_valid : (!main_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_fire  = out_valid && out_ready;

    // Buffer next-state: flush wins, then drain/refill, then fill
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            if (skid_valid) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_d = in_entry;
                end
            end
        end else if (in_fire) begin
            if (!main_valid) begin
                main_valid_d = 1'b1;
                main_d       = in_entry;
            end else if (SKID_EN) begin
                skid_valid_d = 1'b1;
                skid_d       = in_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign out_pc          = main_q.pc;
    assign out_instr       = main_q.instr;
    assign ras_return_addr = main_q.pc + XLEN'(4);

    // Redirect/target from main; RAS ops only on a retiring, non-flushed entry
    always_comb begin
        out_redirect = 1'b0;
        out_target   = '0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        if (main_valid) begin
            if (main_q.is_jal) begin
                out_redirect = 1'b1;
                out_target   = main_q.jal_target;
            end else if (main_q.cls == RAS_RET || main_q.cls == RAS_CALL_RET) begin
                out_redirect = ras_valid;
                out_target   = ras_predicted_return;
            end
            if (out_fire && !flush) begin
                ras_push = (main_q.cls == RAS_CALL) || (main_q.cls == RAS_CALL_RET);
                ras_pop  = (main_q.cls == RAS_RET)  || (main_q.cls == RAS_CALL_RET);
            end
        end
    end

endmodule
